// File: rtl/ramp_pkg.sv
// Shared constants for the ramp sequencer: default widths, step codes/values and FSM encodings.
package ramp_pkg;

  localparam int unsigned LVL_W_DEF = 12;
  localparam int unsigned DIV_W_DEF = 16;
  localparam int unsigned CYC_W_DEF = 8;

  localparam logic [1:0] STEP_ZERO    = 2'b00;
  localparam logic [1:0] STEP_ONE     = 2'b01;
  localparam logic [1:0] STEP_SIXTEEN = 2'b10;
  localparam logic [1:0] STEP_BIG     = 2'b11;

  localparam logic [LVL_W_DEF-1:0] STEP_VAL_ZERO    = 12'd0;
  localparam logic [LVL_W_DEF-1:0] STEP_VAL_ONE     = 12'd1;
  localparam logic [LVL_W_DEF-1:0] STEP_VAL_SIXTEEN = 12'd16;
  localparam logic [LVL_W_DEF-1:0] STEP_VAL_BIG     = 12'd1290;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] CLEAR = 2'd2;

  function automatic logic [LVL_W_DEF-1:0] step_value(input logic [1:0] code);
    logic [LVL_W_DEF-1:0] val;
    unique case (code)
      STEP_ZERO:    val = STEP_VAL_ZERO;
      STEP_ONE:     val = STEP_VAL_ONE;
      STEP_SIXTEEN: val = STEP_VAL_SIXTEEN;
      default:      val = STEP_VAL_BIG;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/ramp_prescaler.sv
// Rate divider: asserts tick once every div_i+1 un-held cycles.
module ramp_prescaler import ramp_pkg::*; #(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             hold_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             at_div;

  assign at_div = (cnt_q == div_i);
  assign tick_o = !clear_i && !hold_i && at_div;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (!hold_i) begin
      cnt_d = at_div ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ramp_sequencer.sv
// Sequences the 12-bit ramp generator from 0 up to a programmed top without ever wrapping,
// optionally repeating, and counts completed ramps.
module ramp_sequencer import ramp_pkg::*; #(
  parameter int unsigned LVL_W = LVL_W_DEF,
  parameter int unsigned DIV_W = DIV_W_DEF,
  parameter int unsigned CYC_W = CYC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             hold_i,
  input  logic [1:0]       step_sel_i,
  input  logic [DIV_W-1:0] rate_div_i,
  input  logic [LVL_W-1:0] top_i,
  input  logic             continuous_i,
  output logic [1:0]       y_o,
  output logic             ramp_enb_o,
  output logic             delta_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             cfg_err_o,
  output logic [CYC_W-1:0] cycle_cnt_o,
  output logic [LVL_W-1:0] level_o
);

  logic [1:0]       state_q, state_d;
  logic [1:0]       y_q, y_d;
  logic             enb_q, enb_d;
  logic             delta_q, delta_d;
  logic             done_q, done_d;
  logic             cfg_err_q, cfg_err_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;
  logic [LVL_W-1:0] level_q, level_d;

  // Shadow copy of the configuration, sampled only on an accepted start.
  logic [1:0]       step_q, step_d;
  logic [DIV_W-1:0] rate_q, rate_d;
  logic [LVL_W-1:0] top_q, top_d;
  logic             cont_q, cont_d;

  logic             tick;
  logic             presc_clear;
  logic [LVL_W-1:0] step_w;
  logic [LVL_W:0]   sum;
  logic             fits;
  logic [CYC_W-1:0] cnt_inc;

  assign presc_clear = (state_q != RUN) || abort_i;

  ramp_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (presc_clear),
    .hold_i  (hold_i),
    .div_i   (rate_q),
    .tick_o  (tick)
  );

  // One extra bit so that a step past the 12-bit range is detected instead of wrapping.
  assign step_w  = LVL_W'(step_value(step_q));
  assign sum     = {1'b0, level_q} + {1'b0, step_w};
  assign fits    = (sum <= {1'b0, top_q});
  assign cnt_inc = (cnt_q == {CYC_W{1'b1}}) ? cnt_q : cnt_q + CYC_W'(1);

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    enb_d     = enb_q;
    delta_d   = 1'b0;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;
    cnt_d     = cnt_q;
    level_d   = level_q;
    step_d    = step_q;
    rate_d    = rate_q;
    top_d     = top_q;
    cont_d    = cont_q;

    if (abort_i) begin
      state_d = IDLE;
      enb_d   = 1'b0;
      level_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          enb_d = 1'b0;
          if (start_i) begin
            if (step_sel_i == STEP_ZERO) begin
              cfg_err_d = 1'b1;
            end else begin
              step_d  = step_sel_i;
              rate_d  = rate_div_i;
              top_d   = top_i;
              cont_d  = continuous_i;
              cnt_d   = '0;
              level_d = '0;
              y_d     = step_sel_i;
              enb_d   = 1'b1;
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (tick) begin
            if (fits) begin
              delta_d = 1'b1;
              level_d = sum[LVL_W-1:0];
            end else begin
              // Ramp complete: drop enable so the generator clears, report it this cycle.
              state_d = CLEAR;
              enb_d   = 1'b0;
              done_d  = 1'b1;
              cnt_d   = cnt_inc;
              level_d = '0;
            end
          end
        end
        CLEAR: begin
          level_d = '0;
          if (cont_q) begin
            state_d = RUN;
            enb_d   = 1'b1;
          end else begin
            state_d = IDLE;
            enb_d   = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          enb_d   = 1'b0;
          level_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      y_q       <= '0;
      enb_q     <= 1'b0;
      delta_q   <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      cnt_q     <= '0;
      level_q   <= '0;
      step_q    <= STEP_ZERO;
      rate_q    <= '0;
      top_q     <= '0;
      cont_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      enb_q     <= enb_d;
      delta_q   <= delta_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      step_q    <= step_d;
      rate_q    <= rate_d;
      top_q     <= top_d;
      cont_q    <= cont_d;
    end
  end

  assign y_o         = y_q;
  assign ramp_enb_o  = enb_q;
  assign delta_o     = delta_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign cfg_err_o   = cfg_err_q;
  assign cycle_cnt_o = cnt_q;
  assign level_o     = level_q;

endmodule

// File: tb/tb_ramp_sequencer.sv
// Directed bench for ramp_sequencer: table of single ramps plus hand-written corner sequences.
module tb_ramp_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, hold, continuous;
  logic [1:0]  step_sel;
  logic [15:0] rate_div;
  logic [11:0] top;
  logic [1:0]  y;
  logic        ramp_enb, delta, busy, done, cfg_err;
  logic [7:0]  cycle_cnt;
  logic [11:0] level;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ramp_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .abort_i      (abort),
    .hold_i       (hold),
    .step_sel_i   (step_sel),
    .rate_div_i   (rate_div),
    .top_i        (top),
    .continuous_i (continuous),
    .y_o          (y),
    .ramp_enb_o   (ramp_enb),
    .delta_o      (delta),
    .busy_o       (busy),
    .done_o       (done),
    .cfg_err_o    (cfg_err),
    .cycle_cnt_o  (cycle_cnt),
    .level_o      (level)
  );

  typedef struct {
    logic [1:0]  sel;
    int unsigned rdiv;
    int unsigned tp;
    int unsigned n_delta;
    int unsigned final_lvl;
    int unsigned done_k;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned step_of(input logic [1:0] s);
    case (s)
      2'b01:   return 1;
      2'b10:   return 16;
      2'b11:   return 1290;
      default: return 0;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".y"}, 32'(y), 0);
    check({tag, ".enb"}, 32'(ramp_enb), 0);
    check({tag, ".delta"}, 32'(delta), 0);
    check({tag, ".busy"}, 32'(busy), 0);
    check({tag, ".done"}, 32'(done), 0);
    check({tag, ".cfg_err"}, 32'(cfg_err), 0);
    check({tag, ".cnt"}, 32'(cycle_cnt), 0);
    check({tag, ".level"}, 32'(level), 0);
  endtask

  // Single (non-continuous) ramp; k counts cycles after the accepting edge.
  task automatic run_ramp(input vec_t v, input int idx);
    int unsigned st;
    int unsigned lvl;
    int unsigned nd;
    int unsigned dk;
    int unsigned bad;
    int unsigned k;
    st = step_of(v.sel);
    start = 1'b1; step_sel = v.sel; rate_div = 16'(v.rdiv); top = 12'(v.tp); continuous = 1'b0;
    tick1();
    start = 1'b0; step_sel = ~v.sel; rate_div = 16'(v.rdiv + 7); top = 12'(v.tp ^ 12'h5a5);
    check($sformatf("v%0d.y", idx), 32'(y), 32'(v.sel));
    check($sformatf("v%0d.enb", idx), 32'(ramp_enb), 1);
    check($sformatf("v%0d.busy", idx), 32'(busy), 1);
    k = 1; lvl = 0; nd = 0; dk = 0; bad = 0;
    while (dk == 0 && k <= v.done_k + 8) begin
      if (done) begin
        dk = k;
        check($sformatf("v%0d.done_enb", idx), 32'(ramp_enb), 0);
        check($sformatf("v%0d.done_cnt", idx), 32'(cycle_cnt), 1);
        check($sformatf("v%0d.done_lvl", idx), 32'(level), 0);
        check($sformatf("v%0d.done_delta", idx), 32'(delta), 0);
      end else begin
        if (delta) begin
          nd++;
          if (32'(level) != lvl + st) bad++;
          if (((k - 1) % (v.rdiv + 1)) != 0) bad++;
          lvl = 32'(level);
        end else if (32'(level) != lvl) begin
          bad++;
        end
        if (32'(level) > v.tp) bad++;
        tick1();
        k++;
      end
    end
    check($sformatf("v%0d.n_delta", idx), nd, v.n_delta);
    check($sformatf("v%0d.final", idx), lvl, v.final_lvl);
    check($sformatf("v%0d.done_k", idx), dk, v.done_k);
    check($sformatf("v%0d.seq_errs", idx), bad, 0);
    tick1();
    check($sformatf("v%0d.idle_busy", idx), 32'(busy), 0);
    check($sformatf("v%0d.idle_done", idx), 32'(done), 0);
    check($sformatf("v%0d.idle_enb", idx), 32'(ramp_enb), 0);
  endtask

  initial begin
    vecs[0] = '{sel: 2'b01, rdiv: 3, tp: 10,   n_delta: 10,   final_lvl: 10,   done_k: 45};
    vecs[1] = '{sel: 2'b11, rdiv: 0, tp: 4095, n_delta: 3,    final_lvl: 3870, done_k: 5};
    vecs[2] = '{sel: 2'b10, rdiv: 0, tp: 4095, n_delta: 255,  final_lvl: 4080, done_k: 257};
    vecs[3] = '{sel: 2'b01, rdiv: 0, tp: 0,    n_delta: 0,    final_lvl: 0,    done_k: 2};
    vecs[4] = '{sel: 2'b11, rdiv: 1, tp: 1000, n_delta: 0,    final_lvl: 0,    done_k: 3};
    vecs[5] = '{sel: 2'b10, rdiv: 2, tp: 50,   n_delta: 3,    final_lvl: 48,   done_k: 13};
    vecs[6] = '{sel: 2'b01, rdiv: 0, tp: 4095, n_delta: 4095, final_lvl: 4095, done_k: 4097};
    vecs[7] = '{sel: 2'b11, rdiv: 4, tp: 2580, n_delta: 2,    final_lvl: 2580, done_k: 16};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0; continuous = 1'b0;
    step_sel = 2'b00; rate_div = '0; top = '0;
    #23;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick1();

    // Rejected start, then start together with abort.
    start = 1'b1; step_sel = 2'b00; rate_div = 16'd1; top = 12'd100;
    tick1();
    start = 1'b0;
    check("cfg_err.pulse", 32'(cfg_err), 1);
    check("cfg_err.busy", 32'(busy), 0);
    check("cfg_err.enb", 32'(ramp_enb), 0);
    tick1();
    check("cfg_err.clear", 32'(cfg_err), 0);
    start = 1'b1; abort = 1'b1; step_sel = 2'b01;
    tick1();
    start = 1'b0; abort = 1'b0;
    check("st_ab.busy", 32'(busy), 0);
    check("st_ab.enb", 32'(ramp_enb), 0);
    check("st_ab.cfg_err", 32'(cfg_err), 0);

    foreach (vecs[i]) run_ramp(vecs[i], i);

    // Continuous ramps of 1290 with a start while busy that must be ignored.
    begin
      int unsigned lvl, nd, ndone, bad;
      start = 1'b1; step_sel = 2'b11; rate_div = '0; top = 12'd4095; continuous = 1'b1;
      tick1();
      start = 1'b0; step_sel = 2'b01; rate_div = 16'd5; top = 12'd10; continuous = 1'b0;
      lvl = 0; nd = 0; ndone = 0; bad = 0;
      for (int k = 1; k <= 16; k++) begin
        if (delta) begin
          nd++;
          if (32'(level) != lvl + 1290) bad++;
          lvl = 32'(level);
        end
        if (done) begin
          ndone++;
          if (k % 5 != 0) bad++;
          if (ramp_enb) bad++;
          if (32'(cycle_cnt) != ndone) bad++;
          lvl = 0;
        end
        if (k < 16) begin
          start = (k == 2);
          tick1();
        end
      end
      start = 1'b0;
      check("cont.n_delta", nd, 9);
      check("cont.n_done", ndone, 3);
      check("cont.seq_errs", bad, 0);
      check("cont.cnt", 32'(cycle_cnt), 3);
      check("cont.y", 32'(y), 3);
      check("cont.busy", 32'(busy), 1);
      abort = 1'b1;
      tick1();
      abort = 1'b0;
      check("abort.busy", 32'(busy), 0);
      check("abort.enb", 32'(ramp_enb), 0);
      check("abort.level", 32'(level), 0);
      check("abort.cnt", 32'(cycle_cnt), 3);
      check("abort.done", 32'(done), 0);
    end

    // Hold for 5 cycles right after a tick (prescaler at 0).
    start = 1'b1; step_sel = 2'b01; rate_div = 16'd2; top = 12'd100; continuous = 1'b0;
    tick1();
    start = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      check($sformatf("hold.delta_k%0d", k), 32'(delta),
            32'((k == 4) || (k == 7) || (k == 10) || (k == 18)));
      if (k >= 10 && k <= 17) check($sformatf("hold.level_k%0d", k), 32'(level), 3);
      if (k == 10) hold = 1'b1;
      if (k == 15) hold = 1'b0;
      if (k < 18) tick1();
    end
    check("hold.enb", 32'(ramp_enb), 1);
    check("hold.level_after", 32'(level), 4);
    abort = 1'b1;
    tick1();
    abort = 1'b0;

    // Asynchronous reset in the middle of a ramp at level 32.
    start = 1'b1; step_sel = 2'b10; rate_div = '0; top = 12'd4095; continuous = 1'b0;
    tick1();
    start = 1'b0;
    tick1();
    tick1();
    check("mid.level", 32'(level), 32);
    check("mid.delta", 32'(delta), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick1();
    check("post_rst.busy", 32'(busy), 0);
    check("post_rst.enb", 32'(ramp_enb), 0);
    run_ramp(vecs[3], 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
